intt_obuf: RTL
==============

INTT_OBUF -- requirements
Module: intt_obuf

Interface
REQ-001 SHALL have parameter N, default 1<<NTT_STAGE_CNT, coefficients per polynomial (P = N/2 pairs).
REQ-002 SHALL have parameter DW, default DATA_WIDTH, coefficient width.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 rst  input  1  synchronous reset, active-high.
REQ-005 in_en  input  1  a valid coefficient pair is present this cycle; driven by the final INTT stage out_en.
REQ-006 in  input  2xDW  pair k: in[0] = coefficient k, in[1] = coefficient k+P.
REQ-007 in_rdy  output  1  a bank is free or filling; upstream shall not start a polynomial while low.
REQ-008 out_valid  output  1  out_data/out_idx/out_last hold a valid coefficient.
REQ-009 out_ready  input  1  consumer accepts the coefficient when out_valid&out_ready.
REQ-010 out_data  output  DW  coefficient, natural order 0..N-1.
REQ-011 out_idx  output  log2(N)  natural index of out_data.
REQ-012 out_last  output  1  high with out_idx = N-1.
REQ-013 overflow  output  1  sticky: in_en seen while no bank writable.

Function
REQ-014 SHALL hold two banks (A, B); each bank = lo half (idx 0..P-1) and hi half (idx P..N-1), each half P x DW, one write and one read per cycle.
REQ-015 Bank state SHALL be one of EMPTY, FILLING, FULL, DRAINING; reset state EMPTY for both.
REQ-016 Write side SHALL use a write bank pointer (reset A) and pair counter wcnt (reset 0, width log2(P)).
REQ-017 On in_en with write bank EMPTY/FILLING: lo[wcnt] <= in[0], hi[wcnt] <= in[1], wcnt++, bank -> FILLING.
REQ-018 Gaps in in_en SHALL be tolerated: wcnt holds, no write.
REQ-019 On the write with wcnt = P-1: bank -> FULL, wcnt -> 0, write pointer toggles.
REQ-020 in_en while write bank is FULL/DRAINING SHALL drop the pair, leave all state unchanged, set overflow (cleared only by rst).
REQ-021 in_rdy SHALL be registered, = write bank in EMPTY/FILLING after the current edge.
REQ-022 Read side SHALL use read bank pointer (reset A) and coefficient counter rcnt (reset 0, width log2(N)).
REQ-023 Read FSM states: IDLE, FETCH, STREAM; reset IDLE.
REQ-024 IDLE -> FETCH when read bank FULL; bank -> DRAINING; RAM read issued at rcnt (lo if rcnt<P else hi[rcnt-P]).
REQ-025 FETCH -> STREAM next cycle; out_valid rises; RAM read latency 1 cycle; first out_valid exactly 2 cycles after the edge writing the last pair.
REQ-026 In STREAM, out_data/out_idx/out_last SHALL stay stable while out_valid & !out_ready.
REQ-027 Sustained out_ready SHALL give one coefficient per cycle with no bubbles within a polynomial (prefetch/skid register permitted).
REQ-028 On handshake with out_last: bank -> EMPTY, read pointer toggles, rcnt -> 0; if the other bank is FULL, next coefficient (idx 0) valid the cycle after with no bubble beyond one, else -> IDLE, out_valid = 0.
REQ-029 Write finishing a bank and read freeing the other bank in the same cycle SHALL both take effect; in_rdy high next cycle.
REQ-030 Write SHALL never target a DRAINING bank; read SHALL never target a FILLING bank.

Reset
REQ-031 rst SHALL, on the next edge, set both banks EMPTY, pointers A, wcnt = rcnt = 0, read FSM IDLE, out_valid = 0, out_last = 0, out_idx = 0, out_data = 0, overflow = 0, in_rdy = 1.
REQ-032 rst mid-fill or mid-drain SHALL discard the partial polynomial; RAM contents need not be cleared.

Structure
REQ-033 Bank state enum, read FSM enum and N/P constants SHALL live in ntt_pkg.
REQ-034 One sub-module intt_obuf_bank (lo+hi halves, 2-write/1-read, 1-cycle read latency), instantiated twice.

Verification (N=256, DW=12)
REQ-035 128 contiguous pairs in = {k, k+128}, out_ready=1 -> out_data = 0..255 in order, out_last at idx 255, first out_valid 2 cycles after last pair.
REQ-036 Two back-to-back polys (second starting the cycle after the first ends), out_ready=1 -> poly 2 data follows poly 1 with at most one bubble; in_rdy never low before pair 128 of poly 2.
REQ-037 out_ready toggled 1-0-1 every cycle -> each coefficient held stable while stalled, none lost or duplicated, 256 handshakes.
REQ-038 Three polys with out_ready=0 -> in_rdy low after poly 2; pairs of poly 3 dropped; overflow = 1; banks A, B still drain poly 1 then poly 2 intact.
REQ-039 rst at pair 60 of fill and again at idx 100 of drain -> all outputs per REQ-031 next cycle; following fresh poly outputs 0..255 correctly.
REQ-040 in_en with 5-cycle gaps every 16 pairs -> output identical to REQ-035.

Source files
------------

// File: rtl/ntt_pkg.sv
// Shared NTT constants and state encodings for the INTT output buffer.
package ntt_pkg;
  localparam int NTT_STAGE_CNT = 8;
  localparam int DATA_WIDTH    = 12;
  localparam int NTT_N         = 1 << NTT_STAGE_CNT;  // coefficients per polynomial
  localparam int NTT_P         = NTT_N / 2;           // butterfly pairs per polynomial

  typedef enum logic [1:0] {BK_EMPTY, BK_FILLING, BK_FULL, BK_DRAINING} bank_st_e;
  typedef enum logic [1:0] {RD_IDLE, RD_FETCH, RD_STREAM} rd_st_e;

  // A bank accepts pairs only while it is empty or partially filled.
  function automatic logic bk_writable(input bank_st_e s);
    return (s == BK_EMPTY) || (s == BK_FILLING);
  endfunction
endpackage

// File: rtl/intt_obuf_bank.sv
// One ping-pong bank: lo half (idx 0..P-1) and hi half (idx P..N-1),
// both written together with a pair, read one coefficient at a time with
// a registered (1-cycle) output that holds while i_re is low.
module intt_obuf_bank #(
  parameter int P  = 128,
  parameter int DW = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_we,
  input  logic [$clog2(P)-1:0]     i_waddr,
  input  logic [1:0][DW-1:0]       i_wdata,
  input  logic                     i_re,
  input  logic [$clog2(P):0]       i_raddr,
  output logic [DW-1:0]            o_rdata
);
  localparam int PAW = $clog2(P);

  logic [DW-1:0] r_lo [P];
  logic [DW-1:0] r_hi [P];
  logic [DW-1:0] r_rdata;

  // Pair write: both halves at the same pair address, no reset on storage.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_lo[i_waddr] <= i_wdata[0];
      r_hi[i_waddr] <= i_wdata[1];
    end
  end

  // Registered read; MSB of the natural index selects the half.
  always_ff @(posedge clk) begin
    if (rst)
      r_rdata <= '0;
    else if (i_re)
      r_rdata <= i_raddr[PAW] ? r_hi[i_raddr[PAW-1:0]] : r_lo[i_raddr[PAW-1:0]];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/intt_obuf.sv
// INTT output buffer: two ping-pong banks collect butterfly pairs
// {k, k+P} and replay them as a natural-order coefficient stream with
// valid/ready handshake. The bank read register doubles as the output
// register, so a stall just stops advancing the read.
module intt_obuf
  import ntt_pkg::*;
#(
  parameter int N  = NTT_N,
  parameter int DW = DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_en,
  input  logic [1:0][DW-1:0]      in,
  output logic                    in_rdy,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DW-1:0]           out_data,
  output logic [$clog2(N)-1:0]    out_idx,
  output logic                    out_last,
  output logic                    overflow
);
  localparam int P   = N / 2;
  localparam int AW  = $clog2(N);
  localparam int PAW = AW - 1;
  localparam logic [AW-1:0]  IDX_LAST  = AW'(N - 1);
  localparam logic [PAW-1:0] PAIR_LAST = PAW'(P - 1);

  bank_st_e       r_bst [2];
  bank_st_e       w_bst_nxt [2];
  logic           r_wptr, w_wptr_nxt;
  logic [PAW-1:0] r_wcnt, w_wcnt_nxt;
  logic           r_rptr, w_rptr_nxt;
  logic [AW-1:0]  r_rcnt, w_rcnt_nxt;   // next natural index to fetch
  rd_st_e         r_rstate, w_rstate_nxt;
  logic           r_out_valid, w_out_valid_nxt;
  logic [AW-1:0]  r_out_idx, w_out_idx_nxt;
  logic           r_ovf, w_ovf_set;
  logic           r_in_rdy, w_in_rdy_nxt;
  logic [1:0]     w_we, w_re;
  logic           w_hs, w_roth;
  logic [1:0][DW-1:0] w_rdata;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    intt_obuf_bank #(.P(P), .DW(DW)) u_bank (
      .clk     (clk),
      .rst     (rst),
      .i_we    (w_we[b]),
      .i_waddr (r_wcnt),
      .i_wdata (in),
      .i_re    (w_re[b]),
      .i_raddr (r_rcnt),
      .o_rdata (w_rdata[b])
    );
  end

  // Next-state for bank states, write side and read FSM. Write only touches
  // EMPTY/FILLING banks and read only FULL/DRAINING ones, so both sides can
  // update the bank state array in the same cycle without colliding.
  always_comb begin
    w_bst_nxt       = r_bst;
    w_wptr_nxt      = r_wptr;
    w_wcnt_nxt      = r_wcnt;
    w_we            = '0;
    w_ovf_set       = 1'b0;
    w_rptr_nxt      = r_rptr;
    w_rcnt_nxt      = r_rcnt;
    w_rstate_nxt    = r_rstate;
    w_out_valid_nxt = r_out_valid;
    w_out_idx_nxt   = r_out_idx;
    w_re            = '0;
    w_hs            = r_out_valid & out_ready;
    w_roth          = ~r_rptr;

    if (in_en) begin
      if (bk_writable(r_bst[r_wptr])) begin
        w_we[r_wptr] = 1'b1;
        w_wcnt_nxt   = r_wcnt + 1'b1;   // wraps to 0 after the last pair
        if (r_wcnt == PAIR_LAST) begin
          w_bst_nxt[r_wptr] = BK_FULL;
          w_wptr_nxt        = ~r_wptr;
        end else begin
          w_bst_nxt[r_wptr] = BK_FILLING;
        end
      end else begin
        w_ovf_set = 1'b1;
      end
    end

    case (r_rstate)
      RD_IDLE: begin
        if (r_bst[r_rptr] == BK_FULL) begin
          w_bst_nxt[r_rptr] = BK_DRAINING;
          w_rstate_nxt      = RD_FETCH;
        end
      end
      RD_FETCH: begin
        w_re[r_rptr]    = 1'b1;
        w_rcnt_nxt      = r_rcnt + 1'b1;
        w_out_idx_nxt   = r_rcnt;
        w_out_valid_nxt = 1'b1;
        w_rstate_nxt    = RD_STREAM;
      end
      RD_STREAM: begin
        if (w_hs) begin
          if (r_out_idx == IDX_LAST) begin
            w_bst_nxt[r_rptr] = BK_EMPTY;
            w_rptr_nxt        = w_roth;
            if (r_bst[w_roth] == BK_FULL) begin
              // rcnt has wrapped to 0: fetch idx 0 of the other bank now.
              w_bst_nxt[w_roth] = BK_DRAINING;
              w_re[w_roth]      = 1'b1;
              w_rcnt_nxt        = r_rcnt + 1'b1;
              w_out_idx_nxt     = r_rcnt;
            end else begin
              w_rcnt_nxt      = '0;
              w_out_valid_nxt = 1'b0;
              w_rstate_nxt    = RD_IDLE;
            end
          end else begin
            w_re[r_rptr]  = 1'b1;
            w_rcnt_nxt    = r_rcnt + 1'b1;
            w_out_idx_nxt = r_rcnt;
          end
        end
      end
      default: w_rstate_nxt = RD_IDLE;
    endcase

    w_in_rdy_nxt = bk_writable(w_bst_nxt[w_wptr_nxt]);
  end

  // State registers; reset drops any partial polynomial.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bst[0]    <= BK_EMPTY;
      r_bst[1]    <= BK_EMPTY;
      r_wptr      <= 1'b0;
      r_wcnt      <= '0;
      r_rptr      <= 1'b0;
      r_rcnt      <= '0;
      r_rstate    <= RD_IDLE;
      r_out_valid <= 1'b0;
      r_out_idx   <= '0;
      r_ovf       <= 1'b0;
      r_in_rdy    <= 1'b1;
    end else begin
      r_bst       <= w_bst_nxt;
      r_wptr      <= w_wptr_nxt;
      r_wcnt      <= w_wcnt_nxt;
      r_rptr      <= w_rptr_nxt;
      r_rcnt      <= w_rcnt_nxt;
      r_rstate    <= w_rstate_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_idx   <= w_out_idx_nxt;
      r_ovf       <= r_ovf | w_ovf_set;
      r_in_rdy    <= w_in_rdy_nxt;
    end
  end

  assign in_rdy    = r_in_rdy;
  assign out_valid = r_out_valid;
  assign out_idx   = r_out_idx;
  assign out_last  = r_out_valid & (r_out_idx == IDX_LAST);
  assign out_data  = w_rdata[r_rptr];
  assign overflow  = r_ovf;
endmodule
